// File: rtl/fpu_comp_arbiter.sv
// rtl/fpu_comp_arbiter.sv - round-robin arbiter sharing one fp16 comparator
// One operation in flight: grant, single operand beat, wait for result or timeout, respond.
module fpu_comp_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CMP_LAT = 1,
  parameter int TIMEOUT = 8
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic                   rsp_lt,
  output logic                   rsp_err,
  output logic [15:0]            cmp_a_tdata,
  output logic [15:0]            cmp_b_tdata,
  output logic                   cmp_a_tvalid,
  output logic                   cmp_b_tvalid,
  input  logic [7:0]             cmp_result_tdata,
  input  logic                   cmp_result_tvalid,
  output logic                   busy
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(CMP_LAT + TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t               state_q;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [PTR_W-1:0]     grant_q;
  logic [PTR_W-1:0]     grant_d;
  logic                 grant_found;
  logic [PTR_W:0]       scan_idx;
  logic [PTR_W:0]       rr_sum;
  logic [PTR_W-1:0]     rr_next;
  logic [NUM_REQ-1:0]   grant_onehot;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W:0]       cnt_inc;
  logic                 slot_ok;
  logic                 cnt_last;
  logic [15:0]          a_sel;
  logic [15:0]          b_sel;
  logic [15:0]          cmp_a_q;
  logic [15:0]          cmp_b_q;
  logic                 cmp_valid_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic                 rsp_lt_q;
  logic                 rsp_err_q;
  logic                 unused_result_bits;

  // Scan from rr_ptr upward with wrap; first requesting line wins.
  always_comb begin
    grant_found = 1'b0;
    grant_d     = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan_idx >= (PTR_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (PTR_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[scan_idx[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_d     = scan_idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_d == PTR_W'(k)) begin
        a_sel = req_a[16*k +: 16];
        b_sel = req_b[16*k +: 16];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_found && !areset) begin
      req_ready[grant_d] = 1'b1;
    end
  end

  always_comb begin
    grant_onehot          = '0;
    grant_onehot[grant_q] = 1'b1;
  end

  assign rr_sum   = {1'b0, grant_q} + (PTR_W+1)'(1);
  assign rr_next  = (rr_sum == (PTR_W+1)'(NUM_REQ)) ? '0 : rr_sum[PTR_W-1:0];
  assign cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);
  // Results arriving before the expected slot are not ours to take.
  assign slot_ok  = cnt_inc >= (CNT_W+1)'(CMP_LAT);
  assign cnt_last = cnt_q == CNT_W'(CMP_LAT - 1 + TIMEOUT);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      cmp_valid_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_lt_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_found) begin
            grant_q     <= grant_d;
            cmp_a_q     <= a_sel;
            cmp_b_q     <= b_sel;
            cmp_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cmp_valid_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (slot_ok && cmp_result_tvalid) begin
            rsp_lt_q    <= cmp_result_tdata[0];
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= grant_onehot;
            state_q     <= S_RESP;
          end else if (cnt_last) begin
            rsp_lt_q    <= 1'b0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= grant_onehot;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_inc[CNT_W-1:0];
          end
        end
        S_RESP: begin
          if (rsp_ready[grant_q]) begin
            rsp_valid_q <= '0;
            rr_ptr_q    <= rr_next;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign unused_result_bits = ^cmp_result_tdata[7:1];

  assign cmp_a_tdata  = cmp_a_q;
  assign cmp_b_tdata  = cmp_b_q;
  assign cmp_a_tvalid = cmp_valid_q;
  assign cmp_b_tvalid = cmp_valid_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_lt       = rsp_lt_q;
  assign rsp_err      = rsp_err_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpu_comp_arbiter.sv
// tb/tb_fpu_comp_arbiter.sv - directed table-driven bench for fpu_comp_arbiter
module tb_fpu_comp_arbiter;
  localparam int N  = 4;
  localparam int CL = 1;
  localparam int TO = 8;

  logic              aclk = 1'b0;
  logic              areset;
  logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [16*N-1:0]   req_a, req_b;
  logic              rsp_lt, rsp_err;
  logic [15:0]       cmp_a_tdata, cmp_b_tdata;
  logic              cmp_a_tvalid, cmp_b_tvalid;
  logic [7:0]        cmp_result_tdata;
  logic              cmp_result_tvalid;
  logic              busy;
  logic              stall;

  int checks = 0;
  int errors = 0;

  fpu_comp_arbiter #(.NUM_REQ(N), .CMP_LAT(CL), .TIMEOUT(TO)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lt(rsp_lt), .rsp_err(rsp_err),
    .cmp_a_tdata(cmp_a_tdata), .cmp_b_tdata(cmp_b_tdata),
    .cmp_a_tvalid(cmp_a_tvalid), .cmp_b_tvalid(cmp_b_tvalid),
    .cmp_result_tdata(cmp_result_tdata), .cmp_result_tvalid(cmp_result_tvalid),
    .busy(busy)
  );

  always #5 aclk = ~aclk;

  function automatic logic fp16_lt(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] ka, kb;
    if (a[14:0] == 15'd0 && b[14:0] == 15'd0) return 1'b0;
    ka = a[15] ? ~a : {1'b1, a[14:0]};
    kb = b[15] ? ~b : {1'b1, b[14:0]};
    return ka < kb;
  endfunction

  // One-cycle comparator; upper result bits carry junk the arbiter must ignore.
  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      cmp_result_tvalid <= 1'b0;
      cmp_result_tdata  <= 8'h00;
    end else begin
      cmp_result_tvalid <= cmp_a_tvalid && cmp_b_tvalid && !stall;
      cmp_result_tdata  <= {7'h55, fp16_lt(cmp_a_tdata, cmp_b_tdata)};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                        input logic exp_lt, input logic exp_err, input int exp_n);
    logic [N-1:0] oh;
    int n;
    oh = '0;
    oh[idx] = 1'b1;
    req_a[16*idx +: 16] = a;
    req_b[16*idx +: 16] = b;
    req_valid = oh;
    #1;
    chk("req_ready", {28'd0, req_ready}, {28'd0, oh});
    step();
    req_valid = '0;
    chk("issue_a_tvalid", {31'd0, cmp_a_tvalid}, 32'd1);
    chk("issue_b_tvalid", {31'd0, cmp_b_tvalid}, 32'd1);
    chk("issue_a_tdata", {16'd0, cmp_a_tdata}, {16'd0, a});
    chk("issue_b_tdata", {16'd0, cmp_b_tdata}, {16'd0, b});
    n = 0;
    while (rsp_valid == '0 && n < 40) begin
      step();
      n++;
    end
    chk("rsp_latency", n, exp_n);
    chk("rsp_valid", {28'd0, rsp_valid}, {28'd0, oh});
    chk("rsp_lt", {31'd0, rsp_lt}, {31'd0, exp_lt});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    chk("busy_resp", {31'd0, busy}, 32'd1);
  endtask

  task automatic finish_op();
    step();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_rsp_valid", {28'd0, rsp_valid}, 32'd0);
  endtask

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic        lt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int got[$];
    int tacc[$];
    logic saw;

    vecs[0] = '{0, 16'h3C00, 16'h4000, 1'b1};
    vecs[1] = '{1, 16'hC500, 16'hC500, 1'b0};
    vecs[2] = '{2, 16'hBC00, 16'h3C00, 1'b1};
    vecs[3] = '{3, 16'h3C00, 16'hBC00, 1'b0};
    vecs[4] = '{0, 16'h4000, 16'h3C00, 1'b0};
    vecs[5] = '{1, 16'h0000, 16'h8000, 1'b0};
    vecs[6] = '{2, 16'hFC00, 16'h7C00, 1'b1};
    vecs[7] = '{3, 16'h3555, 16'h3556, 1'b1};

    areset    = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    req_a     = '0;
    req_b     = '0;
    stall     = 1'b0;
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
    chk("rst_cmp_tvalid", {31'd0, cmp_a_tvalid | cmp_b_tvalid}, 32'd0);
    chk("rst_cmp_tdata", {cmp_a_tdata, cmp_b_tdata}, 32'd0);
    chk("rst_rsp_flags", {30'd0, rsp_lt, rsp_err}, 32'd0);
    areset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].lt, 1'b0, CL + 1);
      finish_op();
    end

    // Backpressure on requester 2 while requester 0 waits.
    rsp_ready = 4'b1011;
    run_op(2, 16'hBC00, 16'h3C00, 1'b1, 1'b0, CL + 1);
    req_valid = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_rsp_valid", {28'd0, rsp_valid}, 32'h4);
      chk("bp_rsp_lt", {31'd0, rsp_lt}, 32'd1);
      chk("bp_busy", {31'd0, busy}, 32'd1);
      chk("bp_req_ready", {28'd0, req_ready}, 32'd0);
    end
    rsp_ready = 4'b1111;
    step();
    chk("bp_release_busy", {31'd0, busy}, 32'd0);
    chk("bp_release_rsp_valid", {28'd0, rsp_valid}, 32'd0);
    req_valid = 4'b1001;
    #1;
    chk("rr_after_2", {28'd0, req_ready}, 32'h8);
    req_valid = '0;
    step();

    stall = 1'b1;
    run_op(1, 16'hBC00, 16'h3C00, 1'b0, 1'b1, CL + TO + 1);
    finish_op();
    stall = 1'b0;

    // Reset while the arbiter is waiting on a stalled comparator.
    req_a[48 +: 16] = 16'h3C00;
    req_b[48 +: 16] = 16'h4000;
    req_valid = 4'b1000;
    stall = 1'b1;
    step();
    req_valid = '0;
    step();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #3;
    areset = 1'b1;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
    chk("async_rst_cmp", {15'd0, cmp_a_tvalid, cmp_a_tdata}, 32'd0);
    chk("async_rst_flags", {30'd0, rsp_lt, rsp_err}, 32'd0);
    step();
    #2;
    areset = 1'b0;
    stall = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (rsp_valid != '0 || busy) saw = 1'b1;
    end
    chk("no_rsp_after_reset", {31'd0, saw}, 32'd0);

    // All four requesting continuously: 0,1,2,3,0 at CMP_LAT+3 spacing.
    for (int i = 0; i < N; i++) begin
      req_a[16*i +: 16] = 16'h3C00;
      req_b[16*i +: 16] = 16'h4000;
    end
    req_valid = 4'b1111;
    for (int c = 0; c < 40 && got.size() < 5; c++) begin
      #1;
      if (req_ready != '0) begin
        for (int k = N - 1; k >= 0; k--) begin
          if (req_ready[k]) begin
            got.push_back(k);
            tacc.push_back(c);
          end
        end
      end
      step();
    end
    req_valid = '0;
    chk("rr_accepts", got.size(), 5);
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      chk("rr_grant", got[k], k % N);
      if (k > 0) chk("rr_spacing", tacc[k] - tacc[k-1], CL + 3);
    end
    for (int i = 0; i < 6; i++) step();
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_comp_arbiter.md
Name: fpu_comp_arbiter

Overview:
Round-robin arbiter that shares one 16-bit half-precision comparator (fpu_comp_small, 1-cycle registered latency) among NUM_REQ requesters. It grants one requester at a time, issues a single-cycle operand beat to the comparator, and samples the 8-bit result after CMP_LAT cycles. It returns a less-than flag, or an error if the comparator does not respond, to the granted requester with a valid/ready handshake. It sits between compare clients (sort/max units) and the shared comparator.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CMP_LAT, 1, comparator latency in cycles from operand beat to result (1..4)
TIMEOUT, 8, cycles after the expected result slot before a missing result is reported as an error (>=1)

Ports:
aclk  in  1  clock, all logic on posedge
areset  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester request accept (one-hot or zero)
req_a  in  16*NUM_REQ  operand A, requester i at [16i+15:16i]
req_b  in  16*NUM_REQ  operand B, same packing
rsp_valid  out  NUM_REQ  per-requester response valid (one-hot or zero)
rsp_ready  in  NUM_REQ  per-requester response accept
rsp_lt  out  1  1 = A < B (comparator result bit 0), 0 = A >= B
rsp_err  out  1  1 = comparator result missing (timeout)
cmp_a_tdata  out  16  to comparator s_axis_a_tdata
cmp_b_tdata  out  16  to comparator s_axis_b_tdata
cmp_a_tvalid  out  1  to comparator s_axis_a_tvalid
cmp_b_tvalid  out  1  to comparator s_axis_b_tvalid
cmp_result_tdata  in  8  from comparator m_axis_result_tdata
cmp_result_tvalid  in  1  from comparator m_axis_result_tvalid
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, areset=1): state=IDLE, rr_ptr=0, all req_ready/rsp_valid=0, cmp_*_tvalid=0, cmp_*_tdata=0, rsp_lt=0, rsp_err=0, counters=0. Reset mid-operation aborts the operation with no response. The comparator result is ignored until the next ISSUE.
- FSM states:
  - IDLE: if any req_valid, grant the first set bit searching from rr_ptr upward with wrap. In the same cycle, drive req_ready[grant]=1 (combinational from registered state and req_valid), latch req_a/req_b of the grantee, and go to ISSUE. If no req_valid, stay in IDLE.
  - ISSUE: one cycle. cmp_a_tvalid=cmp_b_tvalid=1 and cmp_*_tdata=latched operands. Clear wait counter; go to WAIT.
  - WAIT: cmp_*_tvalid=0, cmp_*_tdata held. Counter increments each cycle.
    - When counter==CMP_LAT-1 (result slot), sample cmp_result_tdata[0] into rsp_lt if cmp_result_tvalid=1, set rsp_err=0, go to RESP.
    - If the slot passes with tvalid=0, keep waiting and sample on the first cycle tvalid=1.
    - If TIMEOUT further cycles elapse, set rsp_err=1, rsp_lt=0, go to RESP.
  - RESP: rsp_valid[grant]=1 with rsp_lt/rsp_err stable. On rsp_ready[grant]=1: set rr_ptr=(grant+1) mod NUM_REQ and go to IDLE. Hold indefinitely otherwise.
- Total latency from request accept to rsp_valid: 1 (ISSUE) + CMP_LAT cycles. Minimum spacing between accepts: CMP_LAT+3 cycles.
- Only one operation is outstanding. req_ready is 0 outside IDLE. A requester that deasserts req_valid before acceptance loses nothing.
- rsp_ready on non-granted lines is ignored. req_valid from the grantee while in RESP is not accepted until IDLE.
- Fairness: after servicing requester i, priority starts at i+1, so every continuously-requesting client is served within NUM_REQ operations.
- Bit 7..1 of cmp_result_tdata are ignored. Operand bits pass unmodified; NaN/Inf ordering is the comparator's concern.

Test Plan:
- Single request: req_valid[0] with A=0x3C00 (1.0) and B=0x4000 (2.0) -> req_ready[0] pulses once, one-cycle cmp tvalid beat, rsp_valid[0] asserted 2 cycles after accept (CMP_LAT=1) with rsp_lt=1 and rsp_err=0.
- Equality and sign: A=B=0xC500 -> rsp_lt=0. A=0xBC00 (-1.0), B=0x3C00 -> rsp_lt=1. A=0x3C00, B=0xBC00 -> rsp_lt=0.
- Round-robin: req_valid=4'b1111 held, rsp_ready always 1 -> grants in order 0,1,2,3,0, each accept spaced CMP_LAT+3=4 cycles apart.
- Backpressure: rsp_ready[2]=0 for 10 cycles -> rsp_valid[2], rsp_lt and busy held; no new req_ready; on release, return to IDLE next cycle.
- Timeout: comparator model holds cmp_result_tvalid=0 -> rsp_valid with rsp_err=1 and rsp_lt=0 after CMP_LAT+TIMEOUT WAIT cycles.
- Reset mid-WAIT: assert areset asynchronously -> all outputs 0 immediately, no rsp_valid after release, and the next request is granted starting from requester 0.
